// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and baud math.
// Used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned FRAME_BITS = 11;

   // Last count value of one bit period (bit lasts max+1 clocks).
   function automatic int unsigned baud_max(
      input int unsigned sys_clk,
      input int unsigned baud
   );
      return (sys_clk / baud) - 1;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..MAX while enabled, held at 0 otherwise.
// tick_o pulses for one clock on the last cycle of each bit period.
module uart_baud_gen #(
   parameter int unsigned MAX = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);

   localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         last;

   assign last = (cnt_q == MAX_C);

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (last) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && last;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1-entry holding register feeding an 11-bit frame shifter.
// Define UART_TX_ODD_PARITY_EN for odd parity; even parity otherwise.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD    = 'd9600,
   parameter int unsigned SYS_CLK = 'd50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_tx,
   output logic       out_busy
);

   localparam int unsigned MAX = baud_max(SYS_CLK, BAUD);
   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   if ((SYS_CLK / BAUD) < 2) begin : g_bad_div
      $error("uart_tx: SYS_CLK/BAUD must be >= 2");
   end

   uart_state_e state_q;
   logic [7:0]  hold_q;
   logic        hold_full_q;
   logic [7:0]  shift_q;
   logic        par_q;
   logic [2:0]  idx_q;
   logic        tx_q;
   logic        busy_q;

   logic        tick;
   logic        par_d;
   logic        accept;

   uart_baud_gen #(
      .MAX (MAX)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q != ST_IDLE),
      .tick_o (tick)
   );

`ifdef UART_TX_ODD_PARITY_EN
   assign par_d = ~^hold_q;
`else
   assign par_d = ^hold_q;
`endif

   assign accept   = in_valid && !hold_full_q;
   assign in_ready = !hold_full_q;
   assign out_tx   = tx_q;
   assign out_busy = busy_q;

   // Accept and load are mutually exclusive (hold_full gates both).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         idx_q       <= '0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         if (accept) begin
            hold_q      <= in_data;
            hold_full_q <= 1'b1;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (hold_full_q) begin
                  shift_q     <= hold_q;
                  par_q       <= par_d;
                  hold_full_q <= 1'b0;
                  state_q     <= ST_START;
                  tx_q        <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            ST_START: begin
               if (tick) begin
                  state_q <= ST_DATA;
                  idx_q   <= '0;
                  tx_q    <= shift_q[0];
               end
            end
            ST_DATA: begin
               if (tick) begin
                  shift_q <= shift_q >> 1;
                  if (idx_q == LAST_IDX) begin
                     state_q <= ST_PARITY;
                     tx_q    <= par_q;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                     tx_q  <= shift_q[1];
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (hold_full_q) begin
                     shift_q     <= hold_q;
                     par_q       <= par_d;
                     hold_full_q <= 1'b0;
                     state_q     <= ST_START;
                     tx_q        <= 1'b0;
                  end else begin
                     state_q <= ST_IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at 10 clocks per bit; frames checked against a byte queue.
// Build with UART_TX_ODD_PARITY_EN to exercise the odd-parity variant.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       out_tx;
   logic       out_busy;

   int checks = 0;
   int failures = 0;
   int frames_done = 0;

   logic [7:0] exp_q[$];
   time        start_q[$];
   logic       obs_par_q[$];
   time        acc_t;

   uart_tx #(
      .BAUD    (9600),
      .SYS_CLK (96000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_tx   (out_tx),
      .out_busy (out_busy)
   );

   always #5 clk = ~clk;

   function automatic logic mpar(input logic [7:0] b);
`ifdef UART_TX_ODD_PARITY_EN
      return ~^b;
`else
      return ^b;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      acc_t = $time;
      exp_q.push_back(b);
      #1;
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic wait_frames(input int n);
      int k;
      k = 0;
      while (frames_done < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("frame_wait", frames_done >= n, 1);
   endtask

   task automatic wait_start(input int n);
      int k;
      k = 0;
      while (start_q.size() <= n && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("start_wait", start_q.size() > n, 1);
   endtask

   // Frame monitor: every clock of every bit must carry the expected level.
   initial begin : mon
      logic [7:0]  b;
      logic [10:0] fr;
      logic        bad;
      logic        aborted;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && out_tx === 1'b0) begin
            start_q.push_back($time);
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", exp_q.size(), 1);
               b = 8'h00;
            end else begin
               b = exp_q.pop_front();
            end
            fr = {1'b1, mpar(b), b, 1'b0};
            aborted = 1'b0;
            for (int k = 0; k < 11 && !aborted; k++) begin
               bad = 1'b0;
               for (int j = 0; j < 10; j++) begin
                  if (k != 0 || j != 0) @(negedge clk);
                  if (rst !== 1'b0) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (k == 9 && j == 0) obs_par_q.push_back(out_tx);
                  if (out_tx !== fr[k] || out_busy !== 1'b1) bad = 1'b1;
               end
               if (!aborted) chk($sformatf("bit%0d_of_%02h", k, b), bad, 0);
            end
            if (!aborted) frames_done++;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int s0;
      int f0;
      int np;
      int hi_bad;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_tx", out_tx, 1);
      chk("rst_busy", out_busy, 0);
      chk("rst_ready", in_ready, 1);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_tx", out_tx, 1);

      // Single byte from idle: latency and frame shape
      s0 = start_q.size();
      send(8'hA5);
      chk("acc_ready_low", in_ready, 0);
      wait_start(s0);
      chk("latency", 32'(start_q[s0] - acc_t), 15);
      wait_frames(1);
      @(negedge clk);
      chk("post_busy", out_busy, 0);
      chk("post_tx", out_tx, 1);

      // Back-to-back frames
      s0 = start_q.size();
      f0 = frames_done;
      send(8'h01);
      send(8'h80);
      chk("b2b_ready_low", in_ready, 0);
      repeat (50) @(negedge clk);
      chk("b2b_ready_mid", in_ready, 0);
      wait_frames(f0 + 2);
      chk("b2b_gap", 32'(start_q[s0 + 1] - start_q[s0]), 1100);

      // in_valid held with changing data while holding register full
      repeat (5) @(negedge clk);
      f0 = frames_done;
      send(8'h3C);
      send(8'hC3);
      in_valid = 1'b1;
      hi_bad = 0;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'($urandom);
         @(negedge clk);
         if (in_ready !== 1'b0) hi_bad++;
      end
      in_valid = 1'b0;
      chk("held_no_ready", hi_bad, 0);
      wait_frames(f0 + 2);

      // Parity values for 0x01 and 0x00
      repeat (5) @(negedge clk);
      f0 = frames_done;
      np = obs_par_q.size();
      send(8'h01);
      send(8'h00);
      wait_frames(f0 + 2);
`ifdef UART_TX_ODD_PARITY_EN
      chk("par_01", obs_par_q[np], 0);
      chk("par_00", obs_par_q[np + 1], 1);
`else
      chk("par_01", obs_par_q[np], 1);
      chk("par_00", obs_par_q[np + 1], 0);
`endif

      // Byte accepted on the edge that ends STOP: one idle clock
      repeat (5) @(negedge clk);
      s0 = start_q.size();
      f0 = frames_done;
      send(8'h5A);
      repeat (110) @(posedge clk);
      #1;
      send(8'h96);
      chk("late_ready_low", in_ready, 0);
      @(negedge clk);
      chk("gap_tx", out_tx, 1);
      chk("gap_busy", out_busy, 0);
      wait_frames(f0 + 2);
      chk("late_gap", 32'(start_q[s0 + 1] - start_q[s0]), 1110);

      // Reset mid-frame with a byte held
      repeat (5) @(negedge clk);
      send(8'hFF);
      send(8'h11);
      repeat (30) @(negedge clk);
      f0 = frames_done;
      #1 rst = 1'b1;
      #1;
      chk("arst_tx", out_tx, 1);
      chk("arst_busy", out_busy, 0);
      chk("arst_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      hi_bad = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (out_tx !== 1'b1 || out_busy !== 1'b0) hi_bad++;
      end
      chk("post_rst_quiet", hi_bad, 0);
      chk("post_rst_frames", frames_done, f0);

      // Recovery after reset
      send(8'hE7);
      wait_frames(f0 + 1);
      repeat (20) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter; the stage that drives the line consumed by the team's UART receiver.
Accepts bytes over a valid/ready handshake into a one-entry holding register, then serialises each byte on out_tx as a frame:
- start bit (0)
- 8 data bits, LSB first
- parity bit
- stop bit (1)
Holding register plus shift register allow back-to-back frames with no idle gap.

Parameters:
BAUD, 'd9600, line bit rate in bits/s.
SYS_CLK, 'd50_000_000, clk frequency in Hz; one bit lasts SYS_CLK/BAUD clocks; SYS_CLK/BAUD must be >= 2 (elaboration-time check).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; asynchronous, active-high (already decided)
in_data  input  8  byte to transmit; sampled when in_valid && in_ready
in_valid  input  1  upstream has a byte
in_ready  output  1  holding register empty; equals !hold_full (combinational from register)
out_tx  output  1  serial line, registered, idles high
out_busy  output  1  registered; 1 from first start-bit cycle through last stop-bit cycle

Behaviour:
- Reset (async, rst=1): out_tx=1, out_busy=0, hold_full=0 (in_ready=1), state=IDLE, bit counter=0, baud counter=0.
- Baud counter: MAX=SYS_CLK/BAUD-1, width $clog2(MAX+1). Counts 0..MAX in every non-IDLE state; each bit holds exactly MAX+1 clocks. Counter is 0 on frame entry and wraps to 0 at MAX.
- Accept: at edge where in_valid && in_ready, in_data is copied to the holding register and hold_full=1. No accept while hold_full=1; in_data is ignored then.
- Load: when (state==IDLE or end of STOP) and hold_full=1:
  - holding byte moves to the shift register;
  - parity = ^byte (even parity);
  - hold_full clears;
  - state becomes START and out_tx=0 on that same edge.
- Latency from IDLE: byte accepted at edge E, out_tx falls at edge E+1.
- States:
  - IDLE: out_tx=1, out_busy=0.
  - START: out_tx=0; at cnt==MAX go to DATA, bit index=0.
  - DATA: out_tx=shift[0]; at cnt==MAX shift right; after index 7 go to PARITY.
  - PARITY: out_tx=parity; at cnt==MAX go to STOP.
  - STOP: out_tx=1; at cnt==MAX go to START if hold_full (back-to-back, exactly one stop bit), else IDLE.
- Frame length: 11 bits = 11*(MAX+1) clocks.
- Simultaneous accept and load cannot occur: load requires hold_full=1, accept requires hold_full=0. A byte accepted during STOP's last cycle is therefore not seen until that edge; the FSM goes to IDLE and loads on the next edge (one-clock gap).
- Reset mid-frame: line returns high immediately; partial frame and held byte discarded.

Optional Feature:
UART_TX_ODD_PARITY_EN:
- Defined: parity bit = ~^byte (odd parity).
- Undefined (default): parity bit = ^byte (even parity).
- Frame length and timing are identical in both builds.

Decomposition:
- Package uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP), DATA_BITS=8, FRAME_BITS=11, and a function returning MAX from (SYS_CLK, BAUD). The receiver reuses the package.
- One sub-module: uart_baud_gen, a bit-period counter with enable input and single-cycle tick at cnt==MAX. It is reusable by the receiver.

Test Plan (SYS_CLK=96000, BAUD=9600, so 10 clocks/bit):
1. Reset: pulse rst mid-frame -> out_tx=1, out_busy=0, in_ready=1 asynchronously. After release, no output until next accept.
2. Single byte 0xA5 from IDLE -> out_tx falls 1 clock after accept. Line carries 0,1,0,1,0,0,1,0,1, parity 0, stop 1, each bit exactly 10 clocks. out_busy drops after 110 clocks.
3. Back-to-back 0x01 then 0x80, second offered during first frame -> in_ready low from the second accept until the second load. Second start bit begins the clock after the first stop bit ends. Parity: 1, then 1.
4. in_valid held high with varying in_data while in_ready=0 -> held byte unchanged. Only the byte present on the accept edge is transmitted.
5. Build with UART_TX_ODD_PARITY_EN, send 0x01 -> parity bit 0. Send 0x00 -> parity bit 1.
6. Byte offered exactly on the last STOP-cycle edge -> FSM enters IDLE for one clock, then START. Total gap between frames = 1 clock.
